// File: rtl/sort_result_reader_pkg.sv
// Shared element width and state encoding for the sorted-array reader.
package sort_result_reader_pkg;

  localparam int unsigned ELEM_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STREAM = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

endpackage

// File: rtl/sort_result_reader_order_checker.sv
// Tracks the previously transferred element and flags the first descending pair.
module order_checker
  import sort_result_reader_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              xfer,
  input  logic              first,
  input  logic [ELEM_W-1:0] data,
  output logic              order_err,
  output logic              err_c
);

  logic [ELEM_W-1:0] prev_q, prev_d;
  logic              err_q, err_d;

  // Compare each non-first transfer against the previous one; the flag is sticky until cleared.
  always_comb begin
    prev_d = prev_q;
    err_d  = err_q;
    err_c  = xfer && !first && (data < prev_q);
    if (clear) begin
      err_d = 1'b0;
    end else begin
      if (xfer) prev_d = data;
      if (err_c) err_d = 1'b1;
    end
  end

  // Checker state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      err_q  <= err_d;
    end
  end

  assign order_err = err_q;

endmodule

// File: rtl/sort_result_reader.sv
// Captures a packed sorted array and streams its elements out with valid/ready handshaking.
module sort_result_reader
  import sort_result_reader_pkg::*;
#(
  parameter int unsigned ARR_WIDTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         array_valid,
  input  logic [ARR_WIDTH*ELEM_W-1:0]  array_in,
  output logic                         array_ack,
  output logic [ELEM_W-1:0]            elem_data,
  output logic [$clog2(ARR_WIDTH)-1:0] elem_index,
  output logic                         elem_valid,
  input  logic                         elem_ready,
  output logic                         elem_last,
  output logic                         done,
  output logic                         sorted_ok,
  output logic                         order_err
);

  localparam int unsigned IDX_W    = $clog2(ARR_WIDTH);
  localparam int unsigned ARR_BITS = ARR_WIDTH * ELEM_W;

  state_e                state_q, state_d;
  logic [ARR_BITS-1:0]   arr_q, arr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ELEM_W-1:0]     data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  ack_q, ack_d;
  logic                  done_q, done_d;
  logic                  sorted_q, sorted_d;

  logic                  capture_c;
  logic                  xfer_c;
  logic                  err_c;
  logic                  order_err_c;
  logic [IDX_W-1:0]      next_idx_c;
  logic [ELEM_W-1:0]     elems_c [ARR_WIDTH];

  // Element view of the captured array.
  for (genvar g = 0; g < ARR_WIDTH; g++) begin : g_elem
    assign elems_c[g] = arr_q[g*ELEM_W +: ELEM_W];
  end

  assign xfer_c     = valid_q && elem_ready;
  assign next_idx_c = idx_q + IDX_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    arr_d     = arr_q;
    idx_d     = idx_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    ack_d     = 1'b0;
    done_d    = 1'b0;
    sorted_d  = 1'b0;
    capture_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (array_valid) begin
          capture_c = 1'b1;
          arr_d     = array_in;
          idx_d     = '0;
          data_d    = array_in[ELEM_W-1:0];
          valid_d   = 1'b1;
          last_d    = 1'b0;
          ack_d     = 1'b1;
          state_d   = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (xfer_c) begin
          if (last_q) begin
            valid_d  = 1'b0;
            last_d   = 1'b0;
            done_d   = 1'b1;
            sorted_d = !(order_err_c || err_c);
            state_d  = ST_DONE;
          end else begin
            idx_d  = next_idx_c;
            data_d = elems_c[next_idx_c];
            last_d = (next_idx_c == IDX_W'(ARR_WIDTH - 1));
          end
        end
      end
      ST_DONE: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      arr_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      sorted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      arr_q    <= arr_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      sorted_q <= sorted_d;
    end
  end

  order_checker u_order_checker (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (capture_c),
    .xfer      (xfer_c),
    .first     (idx_q == '0),
    .data      (data_q),
    .order_err (order_err_c),
    .err_c     (err_c)
  );

  assign array_ack  = ack_q;
  assign elem_data  = data_q;
  assign elem_index = idx_q;
  assign elem_valid = valid_q;
  assign elem_last  = last_q;
  assign done       = done_q;
  assign sorted_ok  = sorted_q;
  assign order_err  = order_err_c;

endmodule

// File: tb/tb_sort_result_reader.sv
// Scoreboard bench for sort_result_reader: directed scenarios plus randomized arrays and backpressure.
module tb_sort_result_reader;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            array_valid = 1'b0;
  logic [N*4-1:0]  array_in = '0;
  logic            array_ack;
  logic [3:0]      elem_data;
  logic [IW-1:0]   elem_index;
  logic            elem_valid;
  logic            elem_ready = 1'b0;
  logic            elem_last;
  logic            done;
  logic            sorted_ok;
  logic            order_err;

  sort_result_reader #(.ARR_WIDTH(N)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .array_valid (array_valid),
    .array_in    (array_in),
    .array_ack   (array_ack),
    .elem_data   (elem_data),
    .elem_index  (elem_index),
    .elem_valid  (elem_valid),
    .elem_ready  (elem_ready),
    .elem_last   (elem_last),
    .done        (done),
    .sorted_ok   (sorted_ok),
    .order_err   (order_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]    data;
    logic [IW-1:0] idx;
    logic          last;
  } elem_t;

  elem_t elem_q[$];
  bit    done_q[$];
  int    ack_pending = 0;
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT activity against the expectation queues on the falling edge.
  bit            stall_q = 0;
  logic [3:0]    hold_data;
  logic [IW-1:0] hold_idx;
  logic          hold_last;
  logic [3:0]    exp_prev = '0;
  bit            exp_err = 0;
  bit            want_done = 0;

  always @(negedge clock) begin
    elem_t e;
    bit    ok;
    if (reset_n) begin
      if (want_done) begin
        check("done_after_last", int'(done), 1);
        want_done = 0;
      end
      if (stall_q) begin
        check("hold_valid", int'(elem_valid), 1);
        check("hold_data", int'(elem_data), int'(hold_data));
        check("hold_index", int'(elem_index), int'(hold_idx));
        check("hold_last", int'(elem_last), int'(hold_last));
      end
      stall_q   = elem_valid && !elem_ready;
      hold_data = elem_data;
      hold_idx  = elem_index;
      hold_last = elem_last;
      if (array_ack) begin
        if (ack_pending == 0) begin
          check("unexpected_ack", 1, 0);
        end else begin
          ack_pending--;
          check("ack_order_err_clear", int'(order_err), 0);
          check("ack_first_valid", int'(elem_valid), 1);
          check("ack_first_index", int'(elem_index), 0);
          exp_err = 0;
        end
      end
      if (elem_valid && elem_ready) begin
        if (elem_q.size() == 0) begin
          check("unexpected_xfer", 1, 0);
        end else begin
          e = elem_q.pop_front();
          check("elem_data", int'(elem_data), int'(e.data));
          check("elem_index", int'(elem_index), int'(e.idx));
          check("elem_last", int'(elem_last), int'(e.last));
          check("order_err_running", int'(order_err), int'(exp_err));
          if (e.idx != 0 && e.data < exp_prev) exp_err = 1;
          exp_prev = e.data;
          if (e.last) want_done = 1;
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          ok = done_q.pop_front();
          check("sorted_ok", int'(sorted_ok), int'(ok));
          check("order_err_at_done", int'(order_err), int'(!ok));
          check("done_valid_low", int'(elem_valid), 0);
        end
      end
    end else begin
      stall_q   = 0;
      want_done = 0;
    end
  end

  // Reference: stream is the elements in index order; sorted when no adjacent pair descends.
  task automatic push_exp(input logic [N*4-1:0] a);
    elem_t e;
    bit ok;
    ok = 1;
    ack_pending++;
    for (int i = 0; i < int'(N); i++) begin
      e.data = a[4*i +: 4];
      e.idx  = IW'(i);
      e.last = (i == int'(N) - 1);
      elem_q.push_back(e);
      if (i > 0 && a[4*i +: 4] < a[4*(i-1) +: 4]) ok = 0;
    end
    done_q.push_back(ok);
  endtask

  // Present an array for one edge; call from IDLE at posedge+1.
  task automatic capture(input logic [N*4-1:0] a);
    push_exp(a);
    array_in    = a;
    array_valid = 1'b1;
    @(posedge clock); #1;
    array_valid = 1'b0;
  endtask

  // Run until all expectations are consumed; returns in IDLE.
  task automatic drain(input bit rnd);
    int n = 0;
    while ((elem_q.size() != 0 || done_q.size() != 0) && n < 200) begin
      @(posedge clock); #1;
      elem_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      n++;
    end
    if (n >= 200) begin
      check("drain_timeout", 1, 0);
      elem_q.delete();
      done_q.delete();
      ack_pending = 0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, int'(elem_valid), 0);
    check({tag, "_data"}, int'(elem_data), 0);
    check({tag, "_index"}, int'(elem_index), 0);
    check({tag, "_last"}, int'(elem_last), 0);
    check({tag, "_ack"}, int'(array_ack), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_sorted"}, int'(sorted_ok), 0);
    check({tag, "_order_err"}, int'(order_err), 0);
  endtask

  task automatic wait_index(input int idx);
    int n = 0;
    while (!(elem_valid && int'(elem_index) == idx) && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 20) check("wait_index_timeout", 1, 0);
  endtask

  initial begin
    logic [N*4-1:0] a;
    logic [3:0] v;

    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_all_zero("idle");

    // Sorted, unsorted, duplicates.
    elem_ready = 1'b1;
    capture(16'h9531); drain(0);
    capture(16'h1359); drain(0);
    capture(16'h7777); drain(0);

    // Backpressure at index 2.
    elem_ready = 1'b1;
    capture(16'h9531);
    wait_index(2);
    elem_ready = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    check("bp_index_held", int'(elem_index), 2);
    check("bp_data_held", int'(elem_data), 5);
    elem_ready = 1'b1;
    drain(0);

    // array_valid during STREAM is ignored.
    capture(16'h9531);
    array_in    = '0;
    array_valid = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    array_valid = 1'b0;
    drain(0);

    // Reset mid-stream, then a fresh capture.
    elem_ready = 1'b1;
    capture(16'h9531);
    wait_index(1);
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    elem_q.delete();
    done_q.delete();
    ack_pending = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    check("post_rst_idle_valid", int'(elem_valid), 0);
    check("post_rst_idle_done", int'(done), 0);
    capture(16'hFA21); drain(0);

    // Random arrays under random backpressure; half forced non-decreasing.
    for (int t = 0; t < 30; t++) begin
      if (t % 2 == 0) begin
        a = N*4'($urandom);
      end else begin
        v = 4'($urandom_range(0, 15));
        for (int i = 0; i < int'(N); i++) begin
          v = v + 4'($urandom_range(0, 15 - int'(v)));
          a[4*i +: 4] = v;
        end
      end
      elem_ready = ($urandom_range(0, 1) != 0);
      capture(a);
      drain(1);
    end

    repeat (3) @(posedge clock);
    check("final_queues_empty", elem_q.size() + done_q.size() + ack_pending, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sort_result_reader.md
SORT_RESULT_READER -- requirements
Module: sort_result_reader

Interface
REQ-001 Parameter ARR_WIDTH, default 4, number of 4-bit elements in the packed array; SHALL be >= 2.
REQ-002 clock  input  1  single clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 array_valid  input  1  sorter output qualifier; the packed array is complete while high.
REQ-005 array_in  input  ARR_WIDTH*4  packed sorted array; element i occupies bits [4i+3:4i].
REQ-006 array_ack  output  1  one-cycle pulse confirming that array_in was captured.
REQ-007 elem_data  output  4  current streamed element.
REQ-008 elem_index  output  clog2(ARR_WIDTH)  index of the current element.
REQ-009 elem_valid  output  1  elem_data/elem_index are valid.
REQ-010 elem_ready  input  1  downstream accepts; a transfer occurs on any edge where elem_valid && elem_ready.
REQ-011 elem_last  output  1  high with elem_valid when elem_index == ARR_WIDTH-1.
REQ-012 done  output  1  one-cycle pulse after the last transfer.
REQ-013 sorted_ok  output  1  valid with done; 1 when the streamed sequence was non-decreasing.
REQ-014 order_err  output  1  sticky flag; set on the first descending pair; cleared on the next capture.

Function
REQ-015 States are IDLE, STREAM and DONE. The block SHALL register its state and all outputs.
REQ-016 In IDLE, on an edge with array_valid=1, the block SHALL capture array_in into an internal register, clear order_err, set elem_index=0, pulse array_ack for exactly the following cycle, and enter STREAM.
REQ-017 array_valid SHALL be ignored outside IDLE; the captured copy SHALL NOT change until the next capture.
REQ-018 In STREAM, elem_valid SHALL be 1 and elem_data SHALL equal captured element[elem_index].
- Latency: the first element is valid in the cycle after the capture edge.
REQ-019 While elem_valid=1 and elem_ready=0, elem_data, elem_index and elem_last SHALL hold stable.
REQ-020 On a transfer with elem_last=0, elem_index SHALL increment by 1. Back-to-back transfers SHALL sustain one element per cycle.
REQ-021 On a transfer with elem_last=1, the block SHALL enter DONE and drop elem_valid in the next cycle.
REQ-022 Order check: on each transfer with index > 0, if elem_data < previous transferred element (unsigned 4-bit compare), order_err SHALL set. Equal values are not an error.
REQ-023 DONE SHALL last exactly one cycle with done=1 and sorted_ok = !order_err, then return to IDLE.
- A new capture is therefore possible no earlier than the cycle after DONE.
REQ-024 In IDLE and DONE, elem_valid SHALL be 0. elem_ready SHALL be ignored when elem_valid=0.

Reset
REQ-025 When reset_n=0, the block SHALL asynchronously force: state=IDLE, captured array=0, elem_index=0, elem_valid=0, elem_last=0, elem_data=0, array_ack=0, done=0, sorted_ok=0, order_err=0.
REQ-026 Reset asserted mid-STREAM SHALL abort the stream with no done pulse. After release, the block SHALL wait for a fresh array_valid.

Structure
REQ-027 A shared package SHALL hold ELEM_W=4 and the state encoding (IDLE=2'b00, STREAM=2'b01, DONE=2'b10). The sorter SHALL use ELEM_W from the same package.
REQ-028 One sub-module, order_checker, SHALL hold the previous-element register, the comparator and the sticky order_err. Everything else stays in sort_result_reader.

Verification
REQ-029 Sorted stream: ARR_WIDTH=4, array_in=16'h9531, array_valid=1 in IDLE, elem_ready=1 -> array_ack once; then elem_data 1,3,5,9 on four consecutive cycles with index 0..3; elem_last on 9; done=1, sorted_ok=1.
REQ-030 Unsorted: array_in=16'h1359 -> stream 9,5,3,1; order_err set after the 2nd transfer; done with sorted_ok=0.
REQ-031 Duplicates: array_in=16'h7777 -> stream 7,7,7,7; order_err=0; sorted_ok=1.
REQ-032 Backpressure: 16'h9531, elem_ready=0 for 3 cycles while index=2 -> elem_data=5 and index=2 held stable; resumes 5,9 after ready=1; exactly 4 transfers total.
REQ-033 Reset mid-operation: reset_n=0 at index=1 -> all outputs 0 immediately, no done; after release, array_valid with 16'hFA21 -> stream 1,2,A,F, sorted_ok=1.
REQ-034 Ignored input: array_in changed to 16'h0000 with array_valid=1 during STREAM of 16'h9531 -> stream remains 1,3,5,9; no extra array_ack.
